sub43_serial: RTL and testbench



---
 rtl/sub43_serial.sv | 107 ++++++++++
 tb/tb_sub43_serial.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sub43_serial.sv
// sub43_serial: bit-serial subtractor DIFF = A - B, one bit per clock, LSB first.
// Operands are latched on a valid/ready handshake, processed over W = WA+1
// clocks through a single full-subtractor cell, then held until consumed.
// All outputs come from registers or are decoded from the state register.
// WB must not exceed WA.
module sub43_serial #(
    parameter int WA = 4,
    parameter int WB = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [WA-1:0] A,
    input  logic [WB-1:0] B,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [WA:0]   DIFF,
    output logic          BORROW,
    output logic          BUSY
);

    localparam int W  = WA + 1;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_res;
    logic          r_br;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_diff;
    logic          r_borrow;

    logic          w_a;
    logic          w_b;
    logic          w_d;
    logic          w_br_next;
    logic          w_last;
    logic [W-1:0]  w_res_next;

    // Full-subtractor cell on the current LSBs with the running borrow.
    assign w_a        = r_a[0];
    assign w_b        = r_b[0];
    assign w_d        = w_a ^ w_b ^ r_br;
    assign w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_last     = (r_cnt == CW'(W - 1));
    assign w_res_next = {w_d, r_res[W-1:1]};

    // Handshake and status flags decode straight from the state register.
    assign IN_READY  = (r_state == IDLE);
    assign BUSY      = (r_state == SHIFT);
    assign OUT_VALID = (r_state == DONE);
    assign DIFF      = r_diff;
    assign BORROW    = r_borrow;

    // Control FSM and serial datapath; reset abandons any operation in flight.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_a     <= {{(W-WA){1'b0}}, A};
                        r_b     <= {{(W-WB){1'b0}}, B};
                        r_res   <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Publish only a complete result; DIFF/BORROW stay put otherwise.
                        r_diff   <= w_res_next;
                        r_borrow <= w_br_next;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub43_serial.sv
// Directed and exhaustive checks for sub43_serial at default widths.
module tb_sub43_serial;

    logic       CLK;
    logic       RST_N;
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] A;
    logic [2:0] B;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [4:0] DIFF;
    logic       BORROW;
    logic       BUSY;

    int total    = 0;
    int pass_cnt = 0;
    int ops_done = 0;
    int hs_mon   = 0;

    sub43_serial dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .DIFF     (DIFF),
        .BORROW   (BORROW),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count output handshakes independently of the stimulus.
    always @(posedge CLK) begin
        if (RST_N && OUT_VALID && OUT_READY) hs_mon++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full operation: accept, wait for result, optional stall, consume.
    task automatic do_op(input string tag, input logic [3:0] a, input logic [2:0] b,
                         input logic [4:0] ed, input logic eb, input int stall);
        int lat;
        logic [4:0] held;
        chk({tag, " in_ready"}, IN_READY, 1);
        A = a; B = b; IN_VALID = 1'b1; OUT_READY = (stall == 0);
        tick();
        IN_VALID = 1'b0;
        A = 4'($urandom); B = 3'($urandom);
        chk({tag, " busy"}, BUSY, 1);
        lat = 0;
        while (!OUT_VALID && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, 5);
        chk({tag, " diff"}, DIFF, ed);
        chk({tag, " borrow"}, BORROW, eb);
        chk({tag, " busy_done"}, BUSY, 0);
        held = DIFF;
        for (int i = 0; i < stall; i++) begin
            IN_VALID = ~IN_VALID;
            A = 4'($urandom); B = 3'($urandom);
            tick();
            chk({tag, " hold_valid"}, OUT_VALID, 1);
            chk({tag, " hold_diff"}, DIFF, held);
            chk({tag, " hold_ready"}, IN_READY, 0);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        tick();
        ops_done++;
        chk({tag, " consumed"}, OUT_VALID, 0);
        chk({tag, " idle"}, IN_READY, 1);
    endtask

    initial begin
        logic [4:0] ed;
        RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; A = '0; B = '0;
        tick(); tick();
        RST_N = 1'b1;
        tick();
        chk("rst in_ready", IN_READY, 1);
        chk("rst out_valid", OUT_VALID, 0);
        chk("rst busy", BUSY, 0);
        chk("rst diff", DIFF, 0);
        chk("rst borrow", BORROW, 0);

        do_op("zero", 4'b0000, 3'b000, 5'b00000, 1'b0, 0);
        do_op("v1",   4'b0001, 3'b001, 5'b00000, 1'b0, 0);
        do_op("v2",   4'b0011, 3'b001, 5'b00010, 1'b0, 0);
        do_op("v3",   4'b0111, 3'b011, 5'b00100, 1'b0, 0);
        do_op("v4",   4'b1111, 3'b111, 5'b01000, 1'b0, 0);
        do_op("neg4", 4'b0011, 3'b111, 5'b11100, 1'b1, 0);
        do_op("neg7", 4'b0000, 3'b111, 5'b11001, 1'b1, 0);
        do_op("bp",   4'b1010, 3'b011, 5'b00111, 1'b0, 6);

        // Abort during the third SHIFT cycle.
        A = 4'b0101; B = 3'b010; IN_VALID = 1'b1; OUT_READY = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick(); tick();
        chk("abort busy", BUSY, 1);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("abort in_ready", IN_READY, 1);
        chk("abort out_valid", OUT_VALID, 0);
        chk("abort busy_low", BUSY, 0);
        chk("abort diff", DIFF, 0);
        chk("abort borrow", BORROW, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort no_pulse", OUT_VALID, 0);
        end
        do_op("post_rst", 4'b1111, 3'b001, 5'b01110, 1'b0, 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 8; b++) begin
                ed = 5'(a - b);
                do_op("exh", 4'(a), 3'(b), ed, (a < b), int'($urandom_range(0, 2)));
            end
        end

        tick();
        chk("handshakes", hs_mon, ops_done);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
